// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-stage requester for the iterative multiply/divide unit.
// Accepts one decoded M-op at a time, presents it to the unit for exactly one
// cycle, waits for the unit's stall to drop, and holds the result for
// writeback on a valid/ready handshake. Flushes never abort the unit; an
// in-flight op is drained instead.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_*                      decoded M-op request (valid/ready)
//   flush_i                    kill in-flight op
//   mul_op_o, op_a_o, op_b_o   op/operands to the unit
//   stall_mul_i, result_i      unit busy flag and result (valid when stall drops)
//   wb_*                       writeback result (valid/ready), err on watchdog timeout
//   busy_o                     controller not idle
//
// State | Meaning
// IDLE  | ready for a new request
// ISSUE | op driven to the unit for one cycle
// WAIT  | unit computing, watchdog running
// DRAIN | flushed while unit busy, wait for unit to finish and discard
// RESP  | result offered to writeback

package riscv_pkg;
  typedef enum logic [3:0] {
    M_NONE   = 4'd0,
    M_MUL    = 4'd1,
    M_MULH   = 4'd2,
    M_MULHSU = 4'd3,
    M_MULHU  = 4'd4,
    M_DIV    = 4'd5,
    M_DIVU   = 4'd6,
    M_REM    = 4'd7,
    M_REMU   = 4'd8
  } mul_op_t;
endpackage

module muldiv_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  mul_op_t          req_op_i,
  input  logic [63:0]      req_a_i,
  input  logic [63:0]      req_b_i,
  input  logic [4:0]       req_rd_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output mul_op_t          mul_op_o,
  output logic [63:0]      op_a_o,
  output logic [63:0]      op_b_o,
  input  logic             stall_mul_i,
  input  logic [63:0]      result_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [63:0]      wb_data_o,
  output logic             wb_err_o,
  output logic             busy_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  mul_op_t          op_q, op_d;
  mul_op_t          mul_op_q, mul_op_d;
  logic [63:0]      a_q, a_d, b_q, b_d, data_q, data_d;
  logic [4:0]       rd_q, rd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             ready_q, ready_d, busy_q, busy_d, valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    wdog_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          op_d    = req_op_i;
          a_d     = req_a_i;
          b_d     = req_b_i;
          rd_d    = req_rd_i;
          tag_d   = req_tag_i;
          data_d  = '0;
          err_d   = 1'b0;
          state_d = (req_op_i == M_NONE) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_d = flush_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (!stall_mul_i) begin
          data_d  = result_i;
          err_d   = 1'b0;
          state_d = flush_i ? S_IDLE : S_RESP;
        end else if (wdog_q == WD_LAST) begin
          // A flush at the timeout cycle has nothing left to drain for.
          data_d  = '0;
          err_d   = 1'b1;
          state_d = flush_i ? S_IDLE : S_RESP;
        end else begin
          // Watchdog keeps counting into DRAIN: the bound is on total time
          // spent waiting for the unit, not per state.
          wdog_d  = wdog_q + 1'b1;
          state_d = flush_i ? S_DRAIN : S_WAIT;
        end
      end
      S_DRAIN: begin
        if (!stall_mul_i || wdog_q == WD_LAST) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        if (flush_i || wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    mul_op_d = (state_d == S_ISSUE) ? op_d : M_NONE;
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    valid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= M_NONE;
      mul_op_q <= M_NONE;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mul_op_q <= mul_op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign req_ready_o = ready_q;
  assign mul_op_o    = mul_op_q;
  assign op_a_o      = a_q;
  assign op_b_o      = b_q;
  assign wb_valid_o  = valid_q;
  assign wb_rd_o     = rd_q;
  assign wb_tag_o    = tag_q;
  assign wb_data_o   = data_q;
  assign wb_err_o    = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: directed scenarios followed by randomized
// transactions, checked cycle by cycle against expected latency/result.
module tb_muldiv_issue_ctrl;
  import riscv_pkg::*;

  localparam int TO = 40;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  mul_op_t       req_op_i = M_NONE;
  logic [63:0]   req_a_i = '0, req_b_i = '0;
  logic [4:0]    req_rd_i = '0;
  logic [TW-1:0] req_tag_i = '0;
  logic          flush_i = 1'b0;
  mul_op_t       mul_op_o;
  logic [63:0]   op_a_o, op_b_o;
  logic          stall_mul_i;
  logic [63:0]   result_i;
  logic          wb_valid_o;
  logic          wb_ready_i = 1'b0;
  logic [4:0]    wb_rd_o;
  logic [TW-1:0] wb_tag_o;
  logic [63:0]   wb_data_o;
  logic          wb_err_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(TO), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_rd_i(req_rd_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .mul_op_o(mul_op_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .stall_mul_i(stall_mul_i), .result_i(result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o),
    .wb_err_o(wb_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Architectural result of an M-op.
  function automatic logic [63:0] ref_result(mul_op_t op, logic [63:0] a, logic [63:0] b);
    logic signed [127:0] p;
    logic signed [63:0]  sa, sb;
    logic [63:0]         min_neg;
    sa = a;
    sb = b;
    min_neg = 64'h8000_0000_0000_0000;
    case (op)
      M_MUL:    return a * b;
      M_MULH:   begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
      M_MULHSU: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});       return p[127:64]; end
      M_MULHU:  begin p = {64'b0, a} * {64'b0, b};                               return p[127:64]; end
      M_DIV: begin
        if (b == 0) return '1;
        if (a == min_neg && b == '1) return a;
        return sa / sb;
      end
      M_DIVU:   return (b == 0) ? '1 : a / b;
      M_REM: begin
        if (b == 0) return a;
        if (a == min_neg && b == '1) return '0;
        return sa % sb;
      end
      M_REMU:   return (b == 0) ? a : a % b;
      default:  return '0;
    endcase
  endfunction

  // Cycle, counted from the accept edge, in which the unit reports done.
  function automatic int ref_lat(mul_op_t op);
    return (op == M_DIV || op == M_DIVU || op == M_REM || op == M_REMU) ? 34 : 6;
  endfunction

  // Behavioural unit: samples op when idle, stalls, then presents the result
  // in the cycle its stall drops; garbage on result_i otherwise.
  logic        force_stall = 1'b0;
  logic        u_stall;
  int          u_cnt;
  logic [63:0] u_res;
  assign stall_mul_i = u_stall | force_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt    <= 0;
      u_stall  <= 1'b0;
      u_res    <= '0;
      result_i <= '0;
    end else if (u_cnt == 0) begin
      result_i <= {$urandom, $urandom};
      if (mul_op_o != M_NONE) begin
        u_res   <= ref_result(mul_op_o, op_a_o, op_b_o);
        u_cnt   <= ref_lat(mul_op_o) - 2;
        u_stall <= 1'b1;
      end
    end else if (u_cnt == 1) begin
      u_cnt    <= 0;
      u_stall  <= 1'b0;
      result_i <= u_res;
    end else begin
      u_cnt    <= u_cnt - 1;
      result_i <= {$urandom, $urandom};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_mul_op"}, mul_op_o, M_NONE);
    chk({tag, "_op_a"}, op_a_o, 0);
    chk({tag, "_op_b"}, op_b_o, 0);
    chk({tag, "_valid"}, wb_valid_o, 0);
    chk({tag, "_rd"}, wb_rd_o, 0);
    chk({tag, "_tag"}, wb_tag_o, 0);
    chk({tag, "_data"}, wb_data_o, 0);
    chk({tag, "_err"}, wb_err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  // Called at a negedge with the controller idle; returns at the negedge
  // where it is idle again. mode 0: normal writeback after d stall cycles,
  // 1: flush in cycle fk while executing, 2: flush in the RESP cycle d.
  task automatic run_txn(input mul_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [TW-1:0] tag,
                         input int mode, input int d, input int fk);
    int vs, endk;
    logic [63:0] exp;
    logic inwin;
    vs   = (op == M_NONE) ? 1 : ref_lat(op) + 1;
    endk = (mode == 1) ? vs : vs + d + 1;
    exp  = ref_result(op, a, b);
    chk("ready_pre", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_op_i = op; req_a_i = a; req_b_i = b; req_rd_i = rd; req_tag_i = tag;
    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      req_valid_i = 1'b0; wb_ready_i = 1'b0; flush_i = 1'b0;
      inwin = (mode != 1) && (k >= vs) && (k < endk);
      chk("ready", req_ready_o, k == endk);
      chk("busy", busy_o, k != endk);
      chk("valid", wb_valid_o, inwin);
      chk("mul_op", mul_op_o, (k == 1 && op != M_NONE) ? op : M_NONE);
      chk("op_a", op_a_o, a);
      chk("op_b", op_b_o, b);
      if (inwin) begin
        chk("wb_data", wb_data_o, exp);
        chk("wb_rd", wb_rd_o, rd);
        chk("wb_tag", wb_tag_o, tag);
        chk("wb_err", wb_err_o, 0);
      end
      if (k < endk) begin
        // Garbage requests while busy must be ignored.
        req_valid_i = 1'($urandom_range(0, 1));
        req_op_i = mul_op_t'(4'($urandom_range(0, 8)));
        req_a_i = {$urandom, $urandom}; req_b_i = {$urandom, $urandom};
        req_rd_i = 5'($urandom); req_tag_i = TW'($urandom);
        if (mode == 0) wb_ready_i = (k >= vs + d) ? 1'b1 : (k < vs ? 1'($urandom_range(0, 1)) : 1'b0);
        if (mode == 2 && k == vs + d) begin flush_i = 1'b1; wb_ready_i = 1'($urandom_range(0, 1)); end
        if (mode == 1 && k == fk) flush_i = 1'b1;
      end
    end
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 100));
      1: return -64'($urandom_range(1, 100));
      2: return {$urandom, $urandom};
      default: return ($urandom_range(0, 1) != 0) ? 64'd0 : 64'h8000_0000_0000_0000;
    endcase
  endfunction

  initial begin
    mul_op_t op;
    int mode, lat;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(M_MUL, 64'd7, 64'd6, 5'd5, 4'd3, 0, 0, 0);
    run_txn(M_DIV, -64'd20, 64'd3, 5'd9, 4'd1, 0, 1, 0);
    run_txn(M_MUL, 64'd11, 64'd13, 5'd2, 4'd7, 1, 0, 3);
    run_txn(M_MUL, 64'd12, 64'd12, 5'd4, 4'd8, 0, 0, 0);
    run_txn(M_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd6, 4'd2, 0, 5, 0);
    run_txn(M_NONE, 64'd99, 64'd77, 5'd1, 4'd4, 0, 0, 0);

    // Flush in IDLE blocks acceptance.
    req_valid_i = 1'b1; req_op_i = M_MUL; flush_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_ready", req_ready_o, 1);
    chk("flush_idle_busy", busy_o, 0);
    @(negedge clk);
    chk("flush_idle_mul_op", mul_op_o, M_NONE);

    // Watchdog: unit never finishes.
    force_stall = 1'b1;
    req_valid_i = 1'b1; req_op_i = M_DIV; req_a_i = 64'd100; req_b_i = 64'd7;
    req_rd_i = 5'd3; req_tag_i = 4'd5;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      if (k == 41) chk("wd_valid_before", wb_valid_o, 0);
    end
    @(negedge clk);
    chk("wd_valid", wb_valid_o, 1);
    chk("wd_err", wb_err_o, 1);
    chk("wd_data", wb_data_o, 0);
    chk("wd_rd", wb_rd_o, 3);
    wb_ready_i = 1'b1;
    @(negedge clk);
    wb_ready_i = 1'b0;
    chk("wd_idle", req_ready_o, 1);
    chk("wd_valid_after", wb_valid_o, 0);

    // Reset pulse mid-WAIT.
    req_valid_i = 1'b1; req_op_i = M_MUL; req_a_i = 64'd5; req_b_i = 64'd9;
    req_rd_i = 5'd17; req_tag_i = 4'd9;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    force_stall = 1'b0;
    @(negedge clk);
    run_txn(M_REM, -64'd20, 64'd3, 5'd8, 4'd6, 0, 2, 0);

    for (int i = 0; i < 60; i++) begin
      op = mul_op_t'(4'($urandom_range(0, 8)));
      mode = $urandom_range(0, 9) < 7 ? 0 : ($urandom_range(0, 2) < 2 ? 1 : 2);
      if (op == M_NONE && mode == 1) mode = 0;
      lat = (op == M_NONE) ? 1 : ref_lat(op);
      run_txn(op, rand_opnd(), rand_opnd(), 5'($urandom), TW'($urandom),
              mode, $urandom_range(0, 4), $urandom_range(1, lat));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Requester side of the M-extension execute-unit interface.
- Sits in the EX stage between the decode/issue handshake and the iterative multiply/divide unit.
- Accepts one decoded M-op at a time and presents it to the unit using that unit's op/stall protocol.
- Waits for completion, captures the result, and offers it to writeback on a valid/ready handshake. Handles flush without corrupting the unit.

Parameters:
TIMEOUT_CYCLES, 40, maximum cycles spent in WAIT/DRAIN before the watchdog fires (must exceed divide latency of 34)
TAG_W, 4, width of the instruction tag carried alongside the request

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  decoded M-op available
req_ready_o  out  1  controller can accept a request
req_op_i  in  mul_op_t  operation (riscv_pkg)
req_a_i  in  64  rs1 value
req_b_i  in  64  rs2 value
req_rd_i  in  5  destination register
req_tag_i  in  TAG_W  instruction tag
flush_i  in  1  kill in-flight op (branch mispredict/trap)
mul_op_o  out  mul_op_t  op presented to unit
op_a_o  out  64  operand A to unit
op_b_o  out  64  operand B to unit
stall_mul_i  in  1  unit busy indication
result_i  in  64  unit result (valid in the cycle stall_mul_i drops)
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback accepts
wb_rd_o  out  5  destination register
wb_tag_o  out  TAG_W  tag
wb_data_o  out  64  result
wb_err_o  out  1  result invalid due to watchdog timeout
busy_o  out  1  state != IDLE (for hazard unit)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset: state=IDLE; all latched op/operand/rd/tag/result registers = 0; latched op = M_NONE; watchdog = 0.
- Output values at reset: req_ready_o=1, mul_op_o=M_NONE, op_a_o=0, op_b_o=0, wb_valid_o=0, wb_rd_o=0, wb_tag_o=0, wb_data_o=0, wb_err_o=0, busy_o=0.
- op_a_o and op_b_o always drive the latched operands.
- mul_op_o is non-M_NONE only in ISSUE. The unit samples its op in its own IDLE state, so it must see exactly one cycle of a valid op.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - req_ready_o=1.
  - req_valid_i & !flush_i: latch op, a, b, rd, tag.
  - If op=M_NONE: result=0, go to RESP.
  - Otherwise: go to ISSUE.
  - flush_i in the same cycle blocks acceptance.
- ISSUE:
  - mul_op_o = latched op; the unit accepts this cycle.
  - Next state is DRAIN if flush_i, else WAIT.
  - stall_mul_i is ignored in this cycle.
- WAIT:
  - mul_op_o=M_NONE; watchdog increments each cycle.
  - stall_mul_i==0 (unit DONE cycle): capture result_i into wb_data, wb_err=0. Go to IDLE if flush_i, else RESP.
  - flush_i with stall_mul_i==1: go to DRAIN.
- DRAIN:
  - mul_op_o=M_NONE; the unit cannot be aborted.
  - stall_mul_i==0: result discarded, go to IDLE.
- Watchdog:
  - Counts in WAIT and DRAIN, cleared on leaving them.
  - At TIMEOUT_CYCLES in WAIT: go to RESP with wb_err_o=1, wb_data=0.
  - At TIMEOUT_CYCLES in DRAIN: go to IDLE.
- RESP:
  - wb_valid_o=1; wb_rd/tag/data/err are held stable until the handshake.
  - wb_ready_i: go to IDLE.
  - flush_i: drop the result, go to IDLE (flush wins over wb_ready_i).
- Latency from accept edge A:
  - ISSUE at A+1.
  - Multiply: unit DONE at A+6, wb_valid_o at A+7.
  - Divide/remainder: DONE at A+34, wb_valid_o at A+35.
- Back-to-back: the next request is accepted in IDLE, so the unit is always back in its IDLE when ISSUE drives it.
- Reset mid-operation: controller returns to IDLE immediately (the unit shares the reset).

Test Plan:
- MUL a=7 b=6 accepted at cycle 0 -> mul_op_o=M_MUL only in cycle 1; wb_valid_o at cycle 7 with wb_data_o=42, rd/tag echoed.
- DIV a=-20 b=3 -> wb_valid_o at cycle 35, wb_data_o=-6; req_ready_o=0 and busy_o=1 throughout.
- MUL accepted, flush_i asserted in cycle 3 -> DRAIN until the unit stall drops; no wb_valid_o; next request is issued correctly and returns the correct value.
- MULHU with wb_ready_i low for 5 cycles after wb_valid_o -> wb_data_o held stable, single handshake, then IDLE.
- Request with op=M_NONE -> no op presented to the unit; wb_valid_o next cycle with data=0.
- stall_mul_i forced high -> after 40 WAIT cycles wb_valid_o=1, wb_err_o=1, wb_data_o=0; rst_n pulsed mid-WAIT -> all outputs return to reset values asynchronously.
